complex_mag_sqrt: RTL and testbench
===================================

Name: complex_mag_sqrt

Overview:
- Sequential inverse of the complex squaring path: takes a signed complex sample, forms |z|^2 = re^2 + im^2, then recovers |z| with an iterative integer square root.
- Sits downstream of the front-end registers and feeds the sorter with unsigned magnitudes.
- Uses a valid/ready handshake on both sides; it accepts one sample at a time and is not pipelined.

Parameters:
- WIDTH, 8, bit width of each signed input component; also the width of the magnitude output.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-low reset.
- in_valid  input  1  aReal/aImag hold a valid sample.
- in_ready  output  1  block can accept a sample; high only in IDLE.
- aReal  input  WIDTH  real part, two's complement.
- aImag  input  WIDTH  imaginary part, two's complement.
- out_valid  output  1  magnitude/remainder are valid.
- out_ready  input  1  downstream accepts the result.
- magnitude  output  WIDTH  floor(sqrt(re^2+im^2)), unsigned.
- remainder  output  WIDTH+1  (re^2+im^2) - magnitude^2, unsigned.
- sum_sq  output  2*WIDTH  re^2+im^2, unsigned; valid with out_valid.

Behaviour:
- Reset (rst=0, async): state=IDLE, in_ready=1, out_valid=0, magnitude=0, remainder=0, sum_sq=0, internal registers=0.
- Width rules:
  - Squares are signed WIDTH x WIDTH products, each <= 2^(2*WIDTH-2); the most-negative input is legal.
  - The sum is <= 2^(2*WIDTH-1) and fits in 2*WIDTH unsigned bits with no overflow.
  - The root is < 2^WIDTH.
  - The remainder is <= 2*magnitude, so it fits in WIDTH+1 bits.
- FSM states:
  - IDLE: in_ready=1. On in_valid=1, capture aReal/aImag, go to SQUARE.
  - SQUARE (1 cycle): register sum_sq = re^2 + im^2. Clear the root, remainder and bit counter. Go to ROOT.
  - ROOT (WIDTH cycles): restoring digit-by-digit root, one result bit per cycle, MSB first.
    - Each cycle: shift the next 2 bits of sum_sq into the partial remainder.
    - Trial = (root<<2)|1. If remainder >= trial, subtract it and append 1 to the root; otherwise append 0.
    - After WIDTH iterations go to DONE.
  - DONE: out_valid=1; magnitude, remainder and sum_sq are held stable. On out_ready=1, go to IDLE; out_valid drops the next cycle.
- Latency:
  - Accepting edge = edge 0; SQUARE on edge 1; ROOT on edges 2..WIDTH+1.
  - out_valid rises on edge WIDTH+2 (edge 10 for WIDTH=8).
  - If out_ready is already high, DONE lasts one cycle. Minimum initiation interval is WIDTH+4 cycles (12 for WIDTH=8).
- Handshake rules:
  - in_ready=0 in all states except IDLE; in_valid in those states is ignored and no sample is lost silently from the upstream side.
  - While out_valid=1 and out_ready=0, outputs stay constant for any number of cycles.
  - A new input is not accepted in the same cycle as the out_ready release. The first acceptance is the cycle after the return to IDLE.
- Reset mid-operation: asserting rst in any state aborts immediately to IDLE with all reset values; a partial result is never presented.
- Outputs are undefined-free: magnitude, remainder and sum_sq keep their last completed values in IDLE, SQUARE and ROOT. The exception is SQUARE, which updates sum_sq early.

Decomposition:
- Shared package complex_pkg:
  - FSM state encoding: IDLE, SQUARE, ROOT, DONE (2 bits).
  - Helper localparams for widths: SQ_W = 2*WIDTH, REM_W = WIDTH+1, CNT_W = clog2(WIDTH+1).
- Sub-module isqrt_iter (WIDTH):
  - Holds the root/remainder/counter datapath for the ROOT state.
  - Controls: start and step; outputs: root, rem, last.
  - Lets the FSM and squaring stay in the top level and is verifiable standalone.

Test Plan:
- aReal=3, aImag=4, out_ready=1 -> sum_sq=25, magnitude=5, remainder=0; out_valid exactly 10 cycles after acceptance.
- aReal=-128, aImag=-128 -> sum_sq=32768, magnitude=181, remainder=7; no overflow.
- aReal=0, aImag=0 -> sum_sq=0, magnitude=0, remainder=0. aReal=1, aImag=-1 -> sum_sq=2, magnitude=1, remainder=1.
- Backpressure: out_ready=0 for 20 cycles after out_valid -> outputs stable, in_ready=0, extra in_valid pulses ignored. Release -> out_valid low next cycle, in_ready high.
- Back-to-back with in_valid held high, inputs (6,8) then (-5,12) -> magnitudes 10 then 13, both remainder 0; second acceptance occurs exactly 12 cycles after the first.
- rst pulled low during ROOT (edge 5) -> out_valid=0, in_ready=1 asynchronously. Next sample (7,24) -> magnitude 25, correct latency.

Source files
------------

// File: rtl/complex_pkg.sv
// Shared definitions for the complex magnitude block: FSM encoding and
// width helpers derived from the component width.
package complex_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SQUARE = 2'd1,
    ST_ROOT   = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  function automatic int sq_w(input int w);
    return 2 * w;
  endfunction

  function automatic int rem_w(input int w);
    return w + 1;
  endfunction

  function automatic int cnt_w(input int w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/complex_mag_sqrt_isqrt.sv
// Restoring digit-by-digit integer square root, one root bit per step,
// consuming two radicand bits per step from the MSB end.
module isqrt_iter
  import complex_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 step,
  input  logic [2*WIDTH-1:0]   radicand,
  output logic [WIDTH-1:0]     root,
  output logic [WIDTH:0]       rem,
  output logic                 last
);

  localparam int SQ_W  = sq_w(WIDTH);
  localparam int REM_W = rem_w(WIDTH);
  localparam int CNT_W = cnt_w(WIDTH);

  logic [SQ_W-1:0]  r_rad;
  logic [WIDTH-1:0] r_root;
  logic [REM_W-1:0] r_rem;
  logic [CNT_W-1:0] r_cnt;

  // Shifted remainder needs two extra bits above the stored remainder
  logic [REM_W+1:0] w_rem_sh;
  logic [REM_W+1:0] w_trial;
  logic [REM_W+1:0] w_diff;
  logic             w_ge;

  always_comb begin
    w_rem_sh = {r_rem, r_rad[SQ_W-1 -: 2]};
    w_trial  = {1'b0, r_root, 2'b01};
    w_ge     = (w_rem_sh >= w_trial);
    w_diff   = w_rem_sh - w_trial;
  end

  assign last = (r_cnt == CNT_W'(WIDTH));
  assign root = r_root;
  assign rem  = r_rem;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rad  <= '0;
      r_root <= '0;
      r_rem  <= '0;
      r_cnt  <= '0;
    end else if (start) begin
      r_rad  <= radicand;
      r_root <= '0;
      r_rem  <= '0;
      r_cnt  <= '0;
    end else if (step && !last) begin
      r_rad <= r_rad << 2;
      r_cnt <= r_cnt + CNT_W'(1);
      if (w_ge) begin
        r_rem  <= w_diff[REM_W-1:0];
        r_root <= {r_root[WIDTH-2:0], 1'b1};
      end else begin
        r_rem  <= w_rem_sh[REM_W-1:0];
        r_root <= {r_root[WIDTH-2:0], 1'b0};
      end
    end
  end

endmodule

// File: rtl/complex_mag_sqrt.sv
// Complex magnitude: squares a signed complex sample, sums the squares and
// recovers floor(sqrt) with an iterative root. One sample in flight at a time.
module complex_mag_sqrt
  import complex_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [WIDTH-1:0] aReal,
  input  logic signed [WIDTH-1:0] aImag,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [WIDTH-1:0]        magnitude,
  output logic [WIDTH:0]          remainder,
  output logic [2*WIDTH-1:0]      sum_sq
);

  localparam int SQ_W  = sq_w(WIDTH);
  localparam int REM_W = rem_w(WIDTH);

  // Each square is at most 2^(2W-2), so the unsigned sum cannot overflow 2W bits
  function automatic logic [SQ_W-1:0] mag_sq(input logic signed [WIDTH-1:0] re,
                                             input logic signed [WIDTH-1:0] im);
    logic signed [SQ_W-1:0] p_re;
    logic signed [SQ_W-1:0] p_im;
    p_re = re * re;
    p_im = im * im;
    return $unsigned(p_re) + $unsigned(p_im);
  endfunction

  state_t                  r_state;
  logic signed [WIDTH-1:0] r_re;
  logic signed [WIDTH-1:0] r_im;
  logic                    r_in_ready;
  logic                    r_out_valid;
  logic [WIDTH-1:0]        r_mag;
  logic [REM_W-1:0]        r_rem;
  logic [SQ_W-1:0]         r_sum;

  logic [SQ_W-1:0]         w_sum;
  logic                    w_start;
  logic                    w_step;
  logic [WIDTH-1:0]        w_root;
  logic [REM_W-1:0]        w_rem;
  logic                    w_last;

  assign w_sum   = mag_sq(r_re, r_im);
  assign w_start = (r_state == ST_SQUARE);
  assign w_step  = (r_state == ST_ROOT) && !w_last;

  isqrt_iter #(
    .WIDTH (WIDTH)
  ) u_isqrt (
    .clk      (clk),
    .rst      (rst),
    .start    (w_start),
    .step     (w_step),
    .radicand (w_sum),
    .root     (w_root),
    .rem      (w_rem),
    .last     (w_last)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= ST_IDLE;
      r_re        <= '0;
      r_im        <= '0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_mag       <= '0;
      r_rem       <= '0;
      r_sum       <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (in_valid) begin
            r_re       <= aReal;
            r_im       <= aImag;
            r_in_ready <= 1'b0;
            r_state    <= ST_SQUARE;
          end
        end
        ST_SQUARE: begin
          r_sum   <= w_sum;
          r_state <= ST_ROOT;
        end
        // Root results are published only once the iteration has finished
        ST_ROOT: begin
          if (w_last) begin
            r_mag       <= w_root;
            r_rem       <= w_rem;
            r_out_valid <= 1'b1;
            r_state     <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= ST_IDLE;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign magnitude = r_mag;
  assign remainder = r_rem;
  assign sum_sq    = r_sum;

endmodule

// File: tb/tb_complex_mag_sqrt.sv
// Directed scoreboard bench for complex_mag_sqrt (WIDTH=8).
module tb_complex_mag_sqrt;

  localparam int W   = 8;
  localparam int LIM = 60;

  logic                clk = 1'b0;
  logic                rst;
  logic                in_valid;
  logic                in_ready;
  logic signed [W-1:0] aReal;
  logic signed [W-1:0] aImag;
  logic                out_valid;
  logic                out_ready;
  logic [W-1:0]        magnitude;
  logic [W:0]          remainder;
  logic [2*W-1:0]      sum_sq;

  complex_mag_sqrt #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .aReal     (aReal),
    .aImag     (aImag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .magnitude (magnitude),
    .remainder (remainder),
    .sum_sq    (sum_sq)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    longint sum;
    longint mag;
    longint rem;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  function automatic exp_t model(input int re, input int im);
    exp_t e;
    longint s;
    longint m;
    s = longint'(re) * re + longint'(im) * im;
    m = 0;
    while ((m + 1) * (m + 1) <= s) m++;
    e.sum = s;
    e.mag = m;
    e.rem = s - m * m;
    return e;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int re, input int im, input bit push, output int acc);
    int g;
    logic [31:0] vr;
    logic [31:0] vi;
    g = 0;
    while (!in_ready && g < LIM) begin
      tick();
      g++;
    end
    check("send_ready_wait", 64'(g < LIM), 64'd1);
    vr = re;
    vi = im;
    aReal    = vr[W-1:0];
    aImag    = vi[W-1:0];
    in_valid = 1'b1;
    if (push) sb.push_back(model(re, im));
    tick();
    acc      = cyc;
    in_valid = 1'b0;
  endtask

  task automatic collect(input int acc, input string tag);
    int   g;
    exp_t e;
    g = 0;
    while (!out_valid && g < LIM) begin
      tick();
      g++;
    end
    check({tag, "_timeout"}, 64'(g < LIM), 64'd1);
    check({tag, "_latency"}, 64'(cyc - acc), 64'd10);
    check({tag, "_sb_nonempty"}, 64'(sb.size() > 0), 64'd1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check({tag, "_sum_sq"},    64'(sum_sq),    64'(e.sum));
      check({tag, "_magnitude"}, 64'(magnitude), 64'(e.mag));
      check({tag, "_remainder"}, 64'(remainder), 64'(e.rem));
    end
  endtask

  initial begin
    int acc;
    int acc2;
    int g;
    int hits;
    logic [63:0] snap;

    rst       = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    aReal     = '0;
    aImag     = '0;
    tick();
    tick();
    check("rst_in_ready",  64'(in_ready),  64'd1);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_magnitude", 64'(magnitude), 64'd0);
    check("rst_remainder", 64'(remainder), 64'd0);
    check("rst_sum_sq",    64'(sum_sq),    64'd0);
    rst = 1'b1;
    tick();

    // Basic samples with out_ready already high
    send(3, 4, 1'b1, acc);
    collect(acc, "t34");
    tick();
    check("t34_drop_valid", 64'(out_valid), 64'd0);
    check("t34_in_ready",   64'(in_ready),  64'd1);

    send(-128, -128, 1'b1, acc);
    collect(acc, "tneg");
    tick();

    send(0, 0, 1'b1, acc);
    collect(acc, "tzero");
    tick();

    // Backpressure with ignored in_valid pulses
    out_ready = 1'b0;
    send(1, -1, 1'b1, acc);
    collect(acc, "tbp");
    snap = {39'd0, out_valid, in_ready, magnitude, remainder, sum_sq};
    for (int i = 0; i < 20; i++) begin
      in_valid = i[0];
      aReal    = 8'($urandom_range(0, 255));
      aImag    = 8'($urandom_range(0, 255));
      tick();
      check("bp_stable", {39'd0, out_valid, in_ready, magnitude, remainder, sum_sq}, snap);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    check("bp_release_valid", 64'(out_valid), 64'd0);
    check("bp_release_ready", 64'(in_ready),  64'd1);
    hits = 0;
    for (int i = 0; i < 14; i++) begin
      tick();
      if (out_valid) hits++;
    end
    check("bp_no_ghost_output", 64'(hits), 64'd0);

    // Back-to-back with in_valid held high
    aReal    = 8'sd6;
    aImag    = 8'sd8;
    in_valid = 1'b1;
    sb.push_back(model(6, 8));
    tick();
    acc   = cyc;
    aReal = -8'sd5;
    aImag = 8'sd12;
    sb.push_back(model(-5, 12));
    collect(acc, "b2b1");
    g = 0;
    while (!in_ready && g < LIM) begin
      tick();
      g++;
    end
    check("b2b_ready_wait", 64'(g < LIM), 64'd1);
    tick();
    acc2     = cyc;
    in_valid = 1'b0;
    check("b2b_interval",  64'(acc2 - acc), 64'd12);
    check("b2b_accepted",  64'(in_ready),   64'd0);
    collect(acc2, "b2b2");
    tick();

    // Asynchronous reset in the middle of the root iteration
    send(9, 9, 1'b0, acc);
    repeat (5) tick();
    rst = 1'b0;
    #1;
    check("arst_out_valid", 64'(out_valid), 64'd0);
    check("arst_in_ready",  64'(in_ready),  64'd1);
    check("arst_magnitude", 64'(magnitude), 64'd0);
    check("arst_remainder", 64'(remainder), 64'd0);
    check("arst_sum_sq",    64'(sum_sq),    64'd0);
    tick();
    rst = 1'b1;
    tick();
    send(7, 24, 1'b1, acc);
    collect(acc, "t724");
    tick();
    check("sb_drained", 64'(sb.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
